// File: rtl/relm_push_arb.sv
// ---------------------------------------------------------------------------
// relm_push_arb
//
// Round-robin arbiter sharing one ReLM push channel among N requesters.
// Each requester offers a {valid, data} word; the winner's word is
// registered onto out_d the following cycle.  The sink can stall the
// registered word with out_retry.  A lock flag carried in the data lets
// one requester keep the channel for a multi-word message.  An idle
// timeout releases a lock whose owner has stopped sending.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req_d      N requester words, requester i at [(WD+1)*i +: WD+1],
//              bit WD of each word is its valid flag
//   req_retry  per-requester "not taken this cycle" (combinational)
//   out_d      registered push word to the sink, bit WD is valid
//   out_retry  sink did not accept the out_d presented this cycle
//   lock_owner {lock active, owning requester index}; zero when unlocked
// ---------------------------------------------------------------------------
module relm_push_arb #(
    parameter int WD       = 32,
    parameter int N        = 4,
    parameter int WN       = 2,
    parameter int USE_LOCK = 1,
    parameter int LOCKB    = 29,
    parameter int TMO      = 255,
    parameter int WT       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N*(WD+1)-1:0]   req_d,
    output logic [N-1:0]          req_retry,
    output logic [WD:0]           out_d,
    input  logic                  out_retry,
    output logic [WN:0]           lock_owner
);

    logic [WD:0]   out_q,   out_d_d;
    logic [WN-1:0] last_q,  last_d;
    logic          lock_q,  lock_d;
    logic [WN-1:0] owner_q, owner_d;
    logic [WT-1:0] cnt_q,   cnt_d;

    logic [N-1:0]  valid;
    logic [N-1:0]  grant;
    logic          stall;
    logic          found;
    logic [WN-1:0] win;
    logic [WD:0]   win_word;
    logic [WD:0]   own_word;

    for (genvar g = 0; g < N; g++) begin : g_valid
        assign valid[g] = req_d[(WD+1)*g + WD];
    end

    // A held word that the sink refused freezes everything.
    assign stall = out_q[WD] & out_retry;

    // Round-robin search starting just after the last winner.
    always_comb begin
        found = 1'b0;
        win   = last_q;
        for (int k = 1; k <= N; k++) begin
            logic [WN-1:0] cand;
            cand = WN'((int'(last_q) + k) % N);
            if (!found && valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign win_word = req_d[(WD+1)*win +: WD+1];
    assign own_word = req_d[(WD+1)*owner_q +: WD+1];

    always_comb begin
        out_d_d = out_q;
        last_d  = last_q;
        lock_d  = lock_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        grant   = '0;
        if (!stall) begin
            if (lock_q) begin
                if (valid[owner_q]) begin
                    grant[owner_q] = 1'b1;
                    out_d_d        = own_word;
                    cnt_d          = '0;
                    // The unlocked word ends the message but is still sent.
                    if (!own_word[LOCKB]) begin
                        lock_d = 1'b0;
                    end
                end else begin
                    out_d_d[WD] = 1'b0;
                    if (cnt_q + 1'b1 >= WT'(TMO)) begin
                        lock_d = 1'b0;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end else if (found) begin
                grant[win] = 1'b1;
                out_d_d    = win_word;
                last_d     = win;
                if (USE_LOCK != 0 && win_word[LOCKB]) begin
                    lock_d  = 1'b1;
                    owner_d = win;
                    cnt_d   = '0;
                end
            end else begin
                // Nothing to forward: drop valid, keep the stale data bits.
                out_d_d[WD] = 1'b0;
            end
        end
    end

    // Invalid requesters never see retry; everyone is held off in reset.
    assign req_retry = rst_n ? (valid & ~grant) : '1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q   <= '0;
            last_q  <= WN'(N-1);
            lock_q  <= 1'b0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            out_q   <= out_d_d;
            last_q  <= last_d;
            lock_q  <= lock_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_d      = out_q;
    assign lock_owner = lock_q ? {1'b1, owner_q} : '0;

endmodule

// File: tb/tb_relm_push_arb.sv
module tb_relm_push_arb;

    localparam int WD    = 32;
    localparam int N     = 4;
    localparam int WN    = 2;
    localparam int LOCKB = 29;
    localparam int TMO   = 4;
    localparam int WT    = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N*(WD+1)-1:0] req_d;
    logic [N-1:0]        req_retry;
    logic [WD:0]         out_d;
    logic                out_retry;
    logic [WN:0]         lock_owner;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [WD:0] m_out;
    logic        m_lock;
    int          m_last, m_owner, m_idle;
    logic [N-1:0] seen_retry;

    relm_push_arb #(
        .WD(WD), .N(N), .WN(WN), .USE_LOCK(1), .LOCKB(LOCKB), .TMO(TMO), .WT(WT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_d     (req_d),
        .req_retry (req_retry),
        .out_d     (out_d),
        .out_retry (out_retry),
        .lock_owner(lock_owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WD:0] word_of(input logic [N*(WD+1)-1:0] rq, input int i);
        return rq[(WD+1)*i +: WD+1];
    endfunction

    // One clock cycle: drive, check against model mid-cycle, advance model at the edge.
    task automatic cycle(input logic rstn_v, input logic [N*(WD+1)-1:0] rq, input logic ort);
        logic [N-1:0] er;
        logic [WN:0]  el;
        logic [WD:0]  n_out;
        logic         n_lock;
        int           n_last, n_owner, n_idle, g;
        rst_n     = rstn_v;
        req_d     = rq;
        out_retry = ort;
        #4;
        el = '0;
        if (m_lock) begin
            el[WN]     = 1'b1;
            el[WN-1:0] = WN'(m_owner);
        end
        chk("out_d", 64'(out_d), 64'(m_out));
        chk("lock_owner", 64'(lock_owner), 64'(el));
        n_out = m_out; n_lock = m_lock; n_last = m_last; n_owner = m_owner; n_idle = m_idle;
        er = '0;
        for (int i = 0; i < N; i++) er[i] = word_of(rq, i)[WD];
        if (!rstn_v) begin
            er = '1;
            n_out = '0; n_lock = 1'b0; n_last = N - 1; n_owner = 0; n_idle = 0;
        end else if (m_out[WD] && ort) begin
            // stalled: everything holds, every valid requester retried
        end else if (m_lock) begin
            if (word_of(rq, m_owner)[WD]) begin
                er[m_owner] = 1'b0;
                n_out  = word_of(rq, m_owner);
                n_idle = 0;
                if (!n_out[LOCKB]) n_lock = 1'b0;
            end else begin
                n_out[WD] = 1'b0;
                if (m_idle + 1 >= TMO) begin
                    n_lock = 1'b0;
                    n_idle = 0;
                end else begin
                    n_idle = m_idle + 1;
                end
            end
        end else begin
            g = -1;
            for (int k = 1; k <= N; k++)
                if (g < 0 && word_of(rq, (m_last + k) % N)[WD]) g = (m_last + k) % N;
            if (g < 0) begin
                n_out[WD] = 1'b0;
            end else begin
                er[g]  = 1'b0;
                n_out  = word_of(rq, g);
                n_last = g;
                if (n_out[LOCKB]) begin
                    n_lock = 1'b1; n_owner = g; n_idle = 0;
                end
            end
        end
        seen_retry = req_retry;
        chk("req_retry", 64'(req_retry), 64'(er));
        @(posedge clk);
        m_out = n_out; m_lock = n_lock; m_last = n_last; m_owner = n_owner; m_idle = n_idle;
        #1;
    endtask

    function automatic logic [N*(WD+1)-1:0] all_valid(input logic [31:0] base);
        logic [N*(WD+1)-1:0] r;
        for (int i = 0; i < N; i++) r[(WD+1)*i +: WD+1] = {1'b1, base + 32'(i)};
        return r;
    endfunction

    function automatic logic [N*(WD+1)-1:0] one_req(input int i, input logic [31:0] d);
        logic [N*(WD+1)-1:0] r;
        r = '0;
        r[(WD+1)*i +: WD+1] = {1'b1, d};
        return r;
    endfunction

    localparam logic [31:0] LK = 32'h2000_0000;

    initial begin
        logic [N*(WD+1)-1:0] rq;
        logic [31:0] d;
        rst_n = 1'b0; req_d = '0; out_retry = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        m_out = '0; m_lock = 1'b0; m_last = N - 1; m_owner = 0; m_idle = 0;

        // Reset: everything retried, output cleared
        cycle(1'b0, all_valid(32'h10), 1'b0);
        chk("rst_retry", 64'(seen_retry), 64'h0F);
        chk("rst_out", 64'(out_d), 64'h0);

        // Round-robin from requester 0
        for (int g = 0; g < 5; g++) begin
            cycle(1'b1, all_valid(32'h10), 1'b0);
            chk("rr_out", 64'(out_d), {31'h0, 1'b1, 32'h10 + 32'(g % 4)});
            chk("rr_retry", 64'(seen_retry), 64'(4'hF & ~(4'h1 << (g % 4))));
        end

        // Stall holds 0x11
        cycle(1'b1, all_valid(32'h10), 1'b0);
        chk("pre_stall", 64'(out_d), 64'h1_0000_0011);
        for (int s = 0; s < 3; s++) begin
            cycle(1'b1, all_valid(32'h10), 1'b1);
            chk("stall_out", 64'(out_d), 64'h1_0000_0011);
            chk("stall_retry", 64'(seen_retry), 64'h0F);
        end
        cycle(1'b1, all_valid(32'h10), 1'b0);
        chk("post_stall", 64'(out_d), 64'h1_0000_0012);
        chk("post_stall_retry", 64'(seen_retry), 64'hB);

        // Locked three-word message from requester 1 with requester 2 waiting
        cycle(1'b1, one_req(1, LK | 32'hA1) | one_req(2, 32'h20), 1'b0);
        chk("lk_w1", 64'(out_d), 64'h1_2000_00A1);
        chk("lk_own", 64'(lock_owner), 64'h5);
        cycle(1'b1, one_req(1, LK | 32'hA2) | one_req(2, 32'h20), 1'b0);
        chk("lk_w2", 64'(out_d), 64'h1_2000_00A2);
        chk("lk_w2_retry", 64'(seen_retry), 64'h4);
        cycle(1'b1, one_req(1, 32'hA3) | one_req(2, 32'h20), 1'b0);
        chk("lk_w3", 64'(out_d), 64'h1_0000_00A3);
        chk("lk_rel", 64'(lock_owner), 64'h0);
        cycle(1'b1, one_req(2, 32'h20), 1'b0);
        chk("lk_next", 64'(out_d), 64'h1_0000_0020);

        // Idle timeout of a lock held by requester 3
        cycle(1'b1, one_req(3, LK | 32'h30), 1'b0);
        chk("tmo_own", 64'(lock_owner), 64'h7);
        for (int t = 0; t < TMO; t++) begin
            cycle(1'b1, one_req(0, 32'h40), 1'b0);
            chk("tmo_idle", 64'(out_d[WD]), 64'h0);
            chk("tmo_retry", 64'(seen_retry), 64'h1);
            chk("tmo_lock", 64'(lock_owner[WN]), (t == TMO - 1) ? 64'h0 : 64'h1);
        end
        cycle(1'b1, one_req(0, 32'h40), 1'b0);
        chk("tmo_after", 64'(out_d), 64'h1_0000_0040);

        // Reset in the middle of a lock
        cycle(1'b1, one_req(1, LK | 32'h51), 1'b0);
        chk("mid_lock", 64'(lock_owner), 64'h5);
        for (int r = 0; r < 2; r++) begin
            cycle(1'b0, all_valid(32'h50), 1'b0);
            chk("mid_rst_retry", 64'(seen_retry), 64'h0F);
            chk("mid_rst_out", 64'(out_d), 64'h0);
            chk("mid_rst_lock", 64'(lock_owner), 64'h0);
        end
        cycle(1'b1, all_valid(32'h50), 1'b0);
        chk("mid_rst_first", 64'(out_d), 64'h1_0000_0050);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rq = '0;
            for (int i = 0; i < N; i++) begin
                d = $urandom;
                d[LOCKB] = ($urandom_range(0, 3) == 0);
                rq[(WD+1)*i +: WD+1] = {($urandom_range(0, 9) < 6), d};
            end
            cycle(($urandom_range(0, 99) != 0), rq, ($urandom_range(0, 9) < 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
